sample_condition: RTL and testbench

SAMPLE_CONDITION -- requirements
Module: sample_condition

---
 rtl/sample_condition_pkg.sv | 16 +
 rtl/sample_avg_lane.sv | 63 ++++++
 rtl/sample_condition.sv | 119 +++++++++++
 tb/tb_sample_condition.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_condition_pkg.sv
// sample_condition_pkg -- widths, channel count and sign convention shared by the detector chain.
// Revision 1.0
`default_nettype none

package sample_condition_pkg;
   localparam int   CH_NUM   = 4;
   localparam int   DATA_W   = 16;
   localparam int   SUM_W    = 18;
   localparam logic SIGN_NEG = 1'b1;

   typedef logic [1:0]              ch_idx_t;
   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [SUM_W-1:0]  sum_t;
endpackage

`default_nettype wire

// File: rtl/sample_avg_lane.sv
// sample_avg_lane -- per-channel 3-deep history, warm-up counter and registered 4-tap sum.
// Revision 1.0
`default_nettype none

module sample_avg_lane
   import sample_condition_pkg::*;
#(
   parameter int AVG_EN = 1,
   parameter int WARMUP = 3
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    clear,
   input  logic    load,
   input  sample_t data,
   output logic    warm,
   output sum_t    sum
);
   localparam logic [1:0] WARM_MAX = 2'(WARMUP);

   logic [2:0][DATA_W-1:0] hist;
   logic [1:0]             warm_cnt;
   sum_t                   sum_next;

   generate
      if (AVG_EN != 0) begin : g_avg
         always_comb begin
            sum_next = {{2{data[DATA_W-1]}}, data}
                     + {{2{hist[0][DATA_W-1]}}, hist[0]}
                     + {{2{hist[1][DATA_W-1]}}, hist[1]}
                     + {{2{hist[2][DATA_W-1]}}, hist[2]};
         end
      end else begin : g_bypass
         // Pre-scale by 4 so the shared >>2 in stage 2 returns the raw sample.
         always_comb begin
            sum_next = {data, 2'b00};
         end
      end
   endgenerate

   assign warm = (warm_cnt == WARM_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist     <= '0;
         warm_cnt <= '0;
         sum      <= '0;
      end else if (clear) begin
         hist     <= '0;
         warm_cnt <= '0;
      end else if (load) begin
         hist[2] <= hist[1];
         hist[1] <= hist[0];
         hist[0] <= data;
         sum     <= sum_next;
         if (!warm) begin
            warm_cnt <= warm_cnt + 2'd1;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/sample_condition.sv
// sample_condition -- 4-channel ADC conditioning: moving average, warm-up gating, sign/magnitude split.
// Revision 1.0
`default_nettype none

module sample_condition
   import sample_condition_pkg::*;
#(
   parameter int AVG_EN = 1,
   parameter int WARMUP = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              detect_enable,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [1:0]        adc_ch,
   input  logic              adc_valid,
   output logic [DATA_W-1:0] Ch0_Data,
   output logic [DATA_W-1:0] Ch1_Data,
   output logic [DATA_W-1:0] Ch2_Data,
   output logic [DATA_W-1:0] Ch3_Data,
   output logic              Ch0_Data_en,
   output logic              Ch1_Data_en,
   output logic              Ch2_Data_en,
   output logic              Ch3_Data_en,
   output logic              Ch0_Data_sign,
   output logic              Ch1_Data_sign,
   output logic              Ch2_Data_sign,
   output logic              Ch3_Data_sign
);
   logic [CH_NUM-1:0]              lane_warm;
   logic [CH_NUM-1:0]              lane_load;
   sum_t [CH_NUM-1:0]              lane_sum;

   logic                           s1_valid;
   ch_idx_t                        s1_ch;

   sum_t                           sel_sum;
   logic [DATA_W-1:0]              avg;
   logic                           neg;
   logic [DATA_W-1:0]              mag;

   logic [CH_NUM-1:0][DATA_W-1:0]  out_data;
   logic [CH_NUM-1:0]              out_sign;
   logic [CH_NUM-1:0]              out_en;

   generate
      for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
         assign lane_load[i] = adc_valid && detect_enable && (adc_ch == ch_idx_t'(i));

         sample_avg_lane #(
            .AVG_EN (AVG_EN),
            .WARMUP (WARMUP)
         ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (!detect_enable),
            .load  (lane_load[i]),
            .data  (sample_t'(adc_data)),
            .warm  (lane_warm[i]),
            .sum   (lane_sum[i])
         );
      end
   endgenerate

   // Stage 1 only forwards samples from channels that are past warm-up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
      end else begin
         s1_valid <= adc_valid && detect_enable && lane_warm[adc_ch];
         s1_ch    <= adc_ch;
      end
   end

   // Bits [17:2] are the sum arithmetic-shifted by 2 and truncated to 16 bits.
   always_comb begin
      sel_sum = lane_sum[s1_ch];
      avg     = sel_sum[SUM_W-1:2];
      neg     = (avg[DATA_W-1] == SIGN_NEG);
      if (!neg) begin
         mag = avg;
      end else if (avg == 16'h8000) begin
         mag = 16'h7FFF;
      end else begin
         mag = -avg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= '0;
         out_sign <= '0;
         out_en   <= '0;
      end else begin
         out_en <= '0;
         if (s1_valid && detect_enable) begin
            out_en[s1_ch]   <= 1'b1;
            out_data[s1_ch] <= mag;
            out_sign[s1_ch] <= neg;
         end
      end
   end

   assign Ch0_Data      = out_data[0];
   assign Ch1_Data      = out_data[1];
   assign Ch2_Data      = out_data[2];
   assign Ch3_Data      = out_data[3];
   assign Ch0_Data_en   = out_en[0];
   assign Ch1_Data_en   = out_en[1];
   assign Ch2_Data_en   = out_en[2];
   assign Ch3_Data_en   = out_en[3];
   assign Ch0_Data_sign = out_sign[0];
   assign Ch1_Data_sign = out_sign[1];
   assign Ch2_Data_sign = out_sign[2];
   assign Ch3_Data_sign = out_sign[3];
endmodule

`default_nettype wire

// File: tb/tb_sample_condition.sv
// tb_sample_condition -- randomized and directed checks of sample_condition against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_sample_condition;
   localparam int WARMUP = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        detect_enable = 1'b1;
   logic [15:0] adc_data = '0;
   logic [1:0]  adc_ch = '0;
   logic        adc_valid = 1'b0;
   logic [15:0] Ch0_Data, Ch1_Data, Ch2_Data, Ch3_Data;
   logic        Ch0_Data_en, Ch1_Data_en, Ch2_Data_en, Ch3_Data_en;
   logic        Ch0_Data_sign, Ch1_Data_sign, Ch2_Data_sign, Ch3_Data_sign;

   int cmp_n = 0;
   int fail_n = 0;

   // Model: per-channel list of last three samples, sample counts, and a two-slot delay line.
   int          hist [4][3];
   int          cnt  [4];
   logic        p1_v, p2_v;
   logic [1:0]  p1_ch, p2_ch;
   logic [15:0] p1_mag, p2_mag;
   logic        p1_sign, p2_sign;
   logic [15:0] exp_data [4];
   logic [3:0]  exp_sign, exp_en;
   logic        last_de;

   always #5 clk = ~clk;

   sample_condition #(.AVG_EN(1), .WARMUP(WARMUP)) dut (
      .clk           (clk),
      .rst           (rst_n),
      .detect_enable (detect_enable),
      .adc_data      (adc_data),
      .adc_ch        (adc_ch),
      .adc_valid     (adc_valid),
      .Ch0_Data      (Ch0_Data),
      .Ch1_Data      (Ch1_Data),
      .Ch2_Data      (Ch2_Data),
      .Ch3_Data      (Ch3_Data),
      .Ch0_Data_en   (Ch0_Data_en),
      .Ch1_Data_en   (Ch1_Data_en),
      .Ch2_Data_en   (Ch2_Data_en),
      .Ch3_Data_en   (Ch3_Data_en),
      .Ch0_Data_sign (Ch0_Data_sign),
      .Ch1_Data_sign (Ch1_Data_sign),
      .Ch2_Data_sign (Ch2_Data_sign),
      .Ch3_Data_sign (Ch3_Data_sign)
   );

   task automatic model_clear_all();
      for (int c = 0; c < 4; c++) begin
         cnt[c] = 0;
         exp_data[c] = '0;
         for (int k = 0; k < 3; k++) hist[c][k] = 0;
      end
      exp_sign = '0;
      exp_en   = '0;
      p1_v = 1'b0;
      p2_v = 1'b0;
   endtask

   function automatic logic [71:0] observed();
      return {Ch3_Data, Ch2_Data, Ch1_Data, Ch0_Data,
              Ch3_Data_sign, Ch2_Data_sign, Ch1_Data_sign, Ch0_Data_sign,
              Ch3_Data_en, Ch2_Data_en, Ch1_Data_en, Ch0_Data_en};
   endfunction

   // One clock: advance the model past the edge, compare all outputs, then drive the next inputs.
   task automatic step(input logic v, input logic [1:0] ch, input logic signed [15:0] d,
                       input logic de, input string tag);
      logic [71:0] exp_vec, obs_vec;
      int s, a;
      @(posedge clk);
      #1;
      exp_en = '0;
      if (p2_v && last_de) begin
         exp_en[p2_ch]   = 1'b1;
         exp_data[p2_ch] = p2_mag;
         exp_sign[p2_ch] = p2_sign;
      end
      p2_v = p1_v; p2_ch = p1_ch; p2_mag = p1_mag; p2_sign = p1_sign;
      p1_v = 1'b0;
      exp_vec = {exp_data[3], exp_data[2], exp_data[1], exp_data[0], exp_sign, exp_en};
      obs_vec = observed();
      cmp_n++;
      if (obs_vec !== exp_vec) begin
         fail_n++;
         $display("FAIL %s outputs at %0t: got %h expected %h", tag, $time, obs_vec, exp_vec);
      end
      adc_valid = v; adc_ch = ch; adc_data = d; detect_enable = de;
      last_de = de;
      if (!de) begin
         for (int c = 0; c < 4; c++) begin
            cnt[c] = 0;
            for (int k = 0; k < 3; k++) hist[c][k] = 0;
         end
      end else if (v) begin
         s = int'(d) + hist[ch][0] + hist[ch][1] + hist[ch][2];
         hist[ch][2] = hist[ch][1];
         hist[ch][1] = hist[ch][0];
         hist[ch][0] = int'(d);
         if (cnt[ch] >= WARMUP) begin
            a = (s - (((s % 4) + 4) % 4)) / 4;   // floor(s/4)
            p1_v    = 1'b1;
            p1_ch   = ch;
            p1_sign = (a < 0);
            p1_mag  = (a < 0) ? ((a == -32768) ? 16'h7FFF : 16'(-a)) : 16'(a);
         end
         cnt[ch]++;
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'sd0, 1'b1, tag);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp_n++;
      if (observed() !== 72'h0) begin
         fail_n++;
         $display("FAIL reset_state: got %h expected 0", observed());
      end
      rst_n = 1'b1;
      model_clear_all();
      last_de = detect_enable;
   endtask

   task automatic test_warmup();
      for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 16'sd100, 1'b1, "warmup");
      idle(3, "warmup_tail");
      cmp_n++;
      if (Ch0_Data !== 16'd100 || Ch0_Data_sign !== 1'b0) begin
         fail_n++;
         $display("FAIL warmup_value: got %0d/%b expected 100/0", Ch0_Data, Ch0_Data_sign);
      end
   endtask

   task automatic test_negative();
      for (int i = 0; i < 5; i++) step(1'b1, 2'd1, -16'sd400, 1'b1, "negative");
      idle(3, "negative_tail");
      cmp_n++;
      if (Ch1_Data !== 16'd400 || Ch1_Data_sign !== 1'b1) begin
         fail_n++;
         $display("FAIL negative_value: got %0d/%b expected 400/1", Ch1_Data, Ch1_Data_sign);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 16'sh8000, 1'b1, "saturate");
      idle(3, "saturate_tail");
      cmp_n++;
      if (Ch2_Data !== 16'h7FFF || Ch2_Data_sign !== 1'b1) begin
         fail_n++;
         $display("FAIL saturate_value: got %h/%b expected 7fff/1", Ch2_Data, Ch2_Data_sign);
      end
   endtask

   task automatic test_interleave(input string tag);
      for (int i = 0; i < 20; i++)
         step(1'b1, 2'(i % 4), 16'((i % 4) * 1000 - 1500 + i * 13), 1'b1, tag);
      idle(3, {tag, "_tail"});
   endtask

   task automatic test_de_drop();
      step(1'b1, 2'd0, 16'sd777, 1'b1, "de_drop");
      step(1'b1, 2'd1, 16'sd555, 1'b0, "de_drop");
      step(1'b1, 2'd2, 16'sd333, 1'b1, "de_drop");
      test_interleave("de_rewarm");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 16'sd500, 1'b1, "reset_mid_fill");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      adc_valid = 1'b0;
      #1;
      cmp_n++;
      if (observed() !== 72'h0) begin
         fail_n++;
         $display("FAIL reset_mid_clear: got %h expected 0", observed());
      end
      model_clear_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_de = detect_enable;
      idle(4, "reset_mid_after");
   endtask

   task automatic test_random();
      logic signed [15:0] d;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       d = 16'sh8000;
            1:       d = 16'sh7FFF;
            default: d = 16'($urandom);
         endcase
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d,
              $urandom_range(0, 40) != 0, "random");
      end
      idle(3, "random_tail");
   endtask

   initial begin
      model_clear_all();
      last_de = 1'b1;
      test_reset();
      test_warmup();
      test_negative();
      test_saturate();
      test_interleave("interleave");
      test_de_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end
endmodule

`default_nettype wire
